// File: rtl/string_match_pkg.sv
// Shared types and helpers for the streaming multi-pattern matcher.
// Packed patterns hold symbol 0 in the MSBs; sym_lsb() encodes that ordering in one place.
package string_match_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int sym_lsb(input int j, input int max_plen, input int dwidth);
    return (max_plen - 1 - j) * dwidth;
  endfunction

endpackage

// File: rtl/string_match_stream_pattern_slot_cmp.sv
// Combinational hit detector for one pattern slot against the symbol window.
// Window position 0 is the newest symbol; it must equal the pattern's last symbol.
module pattern_slot_cmp
  import string_match_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int MAX_PLEN = 8,
  parameter int LEN_W    = 4
) (
  input  logic [MAX_PLEN*DWIDTH-1:0] i_window,
  input  logic [MAX_PLEN*DWIDTH-1:0] i_pattern,
  input  logic [LEN_W-1:0]           i_len,
  input  logic [LEN_W-1:0]           i_fill,
  output logic                       o_hit
);

  logic [DWIDTH-1:0] w_win_sym [MAX_PLEN];
  logic [DWIDTH-1:0] w_pat_sym [MAX_PLEN];
  logic              w_eq;

  for (genvar j = 0; j < MAX_PLEN; j++) begin : g_unpack
    assign w_win_sym[j] = i_window[j*DWIDTH +: DWIDTH];
    assign w_pat_sym[j] = i_pattern[sym_lsb(j, MAX_PLEN, DWIDTH) +: DWIDTH];
  end

  // One constant-index comparison chain per candidate length, selected by i_len.
  always_comb begin
    o_hit = 1'b0;
    w_eq  = 1'b1;
    for (int l = 1; l <= MAX_PLEN; l++) begin
      w_eq = 1'b1;
      for (int k = 0; k < l; k++) begin
        if (w_win_sym[k] != w_pat_sym[l-1-k]) w_eq = 1'b0;
      end
      if ((LEN_W'(l) == i_len) && (i_fill >= i_len) && w_eq) o_hit = 1'b1;
    end
  end

endmodule

// File: rtl/string_match_stream.sv
// Streaming multi-pattern matcher: pattern table, symbol window and one output register.
// state | meaning: IDLE cfg/start | RUN accept text | DRAIN flush m_last beat | DONE done pulse
module string_match_stream
  import string_match_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int NUM_PAT  = 16,
  parameter int MAX_PLEN = 8,
  parameter int POS_W    = 16,
  parameter int LEN_W    = clog2_min1(MAX_PLEN + 1),
  parameter int IDX_W    = clog2_min1(NUM_PAT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic [MAX_PLEN*DWIDTH-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic [DWIDTH-1:0]          s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [NUM_PAT-1:0]         m_match,
  output logic [POS_W-1:0]           m_pos,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       done
);

  state_t r_state, w_state_next;

  logic [MAX_PLEN*DWIDTH-1:0] r_pat [NUM_PAT];
  logic [LEN_W-1:0]           r_len [NUM_PAT];
  logic [MAX_PLEN*DWIDTH-1:0] r_win;
  logic [MAX_PLEN*DWIDTH-1:0] w_win_next;
  logic [LEN_W-1:0]           r_fill;
  logic [LEN_W-1:0]           w_fill_next;
  logic [POS_W-1:0]           r_pos;
  logic [NUM_PAT-1:0]         w_hit;
  logic                       w_accept;

  logic                       r_m_valid;
  logic [NUM_PAT-1:0]         r_m_match;
  logic [POS_W-1:0]           r_m_pos;
  logic                       r_m_last;

  assign w_accept    = (r_state == RUN) && s_valid && s_ready;
  // Hits are evaluated on the window as it will look after this symbol shifts in.
  assign w_win_next  = (MAX_PLEN*DWIDTH)'({r_win, s_data});
  assign w_fill_next = (r_fill == LEN_W'(MAX_PLEN)) ? r_fill : r_fill + 1'b1;

  for (genvar p = 0; p < NUM_PAT; p++) begin : g_slot
    pattern_slot_cmp #(
      .DWIDTH   (DWIDTH),
      .MAX_PLEN (MAX_PLEN),
      .LEN_W    (LEN_W)
    ) u_cmp (
      .i_window  (w_win_next),
      .i_pattern (r_pat[p]),
      .i_len     (r_len[p]),
      .i_fill    (w_fill_next),
      .o_hit     (w_hit[p])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    done         = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE:  if (start) w_state_next = RUN;
      RUN: begin
        s_ready = !r_m_valid || m_ready;
        if (s_valid && s_ready && s_last) w_state_next = DRAIN;
      end
      DRAIN: if (r_m_valid && m_ready && r_m_last) w_state_next = DONE;
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Over-length patterns are stored as length 0 so the slot stays disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PAT; p++) begin
        r_pat[p] <= '0;
        r_len[p] <= '0;
      end
    end else if ((r_state == IDLE) && cfg_we) begin
      r_pat[cfg_idx] <= cfg_pattern;
      r_len[cfg_idx] <= (cfg_len > LEN_W'(MAX_PLEN)) ? '0 : cfg_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win     <= '0;
      r_fill    <= '0;
      r_pos     <= '0;
      r_m_valid <= 1'b0;
      r_m_match <= '0;
      r_m_pos   <= '0;
      r_m_last  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_win  <= '0;
        r_fill <= '0;
        r_pos  <= '0;
      end
      if (w_accept) begin
        r_win  <= w_win_next;
        r_fill <= w_fill_next;
        r_pos  <= r_pos + 1'b1;
        if ((|w_hit) || s_last) begin
          r_m_valid <= 1'b1;
          r_m_match <= w_hit;
          r_m_pos   <= r_pos;
          r_m_last  <= s_last;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_match = r_m_match;
  assign m_pos   = r_m_pos;
  assign m_last  = r_m_last;

endmodule

// File: tb/tb_string_match_stream.sv
// Self-checking bench for string_match_stream: vector table plus scoreboard of expected beats.
// Runs with NUM_PAT=4, MAX_PLEN=8, POS_W=4 so position wrap is reachable.
module tb_string_match_stream;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int ML = 8;
  localparam int PW = 4;
  localparam int LW = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [IW-1:0]    cfg_idx = '0;
  logic [ML*DW-1:0] cfg_pattern = '0;
  logic [LW-1:0]    cfg_len = '0;
  logic             start = 1'b0;
  logic             s_valid = 1'b0;
  logic [DW-1:0]    s_data = '0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             m_valid;
  logic [NP-1:0]    m_match;
  logic [PW-1:0]    m_pos;
  logic             m_last;
  logic             m_ready = 1'b1;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  string_match_stream #(
    .DWIDTH   (DW),
    .NUM_PAT  (NP),
    .MAX_PLEN (ML),
    .POS_W    (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_match     (m_match),
    .m_pos       (m_pos),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic [7:0] sym;
    logic       last;
    logic       ev;
    logic [3:0] em;
    logic [3:0] ep;
  } vec_t;

  typedef struct {
    logic [3:0] m;
    logic [3:0] p;
    logic       l;
  } beat_t;

  vec_t  v1 [8];
  beat_t exp_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_done   = 0;
  int    d0       = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input string s);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < s.len(); i++) p = {p[55:0], s[i]};
    return p << ((8 - s.len()) * 8);
  endfunction

  // Scoreboard: every handshaked result beat is compared against the queue head.
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (!reset && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got pos %0d match %b, expected no beat", m_pos, m_match);
        end else begin
          b = exp_q.pop_front();
          chk("beat_match", 64'(m_match), 64'(b.m));
          chk("beat_pos",   64'(m_pos),   64'(b.p));
          chk("beat_last",  64'(m_last),  64'(b.l));
        end
      end
    end
  end

  task automatic load(input int idx, input string s, input int len);
    cfg_we      = 1'b1;
    cfg_idx     = IW'(idx);
    cfg_pattern = pack(s);
    cfg_len     = LW'(len);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic start_frame();
    d0    = n_done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] sym, input logic last, input logic ev,
                      input logic [3:0] em, input logic [3:0] ep);
    int    n;
    beat_t b;
    s_valid = 1'b1;
    s_data  = sym;
    s_last  = last;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_ready", 64'(s_ready), 64'(1));
    if (s_ready && ev) begin
      b.m = em;
      b.p = ep;
      b.l = last;
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_frame();
    int n;
    n = 0;
    while (n_done == d0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(n_done - d0), 64'(1));
    chk("busy_idle",   64'(busy), 64'(0));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic load_case1();
    load(0, "abc", 3);
    load(1, "cab", 3);
    load(2, "ab", 2);
    load(3, "", 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    chk({tag, "_m_match"}, 64'(m_match), 64'(0));
    chk({tag, "_m_pos"},   64'(m_pos),   64'(0));
    chk({tag, "_m_last"},  64'(m_last),  64'(0));
    chk({tag, "_busy"},    64'(busy),    64'(0));
    chk({tag, "_done"},    64'(done),    64'(0));
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    string t3;
    v1[0] = '{8'h61, 1'b0, 1'b0, 4'b0000, 4'd0};
    v1[1] = '{8'h62, 1'b0, 1'b1, 4'b0100, 4'd1};
    v1[2] = '{8'h63, 1'b0, 1'b1, 4'b0001, 4'd2};
    v1[3] = '{8'h61, 1'b0, 1'b0, 4'b0000, 4'd3};
    v1[4] = '{8'h62, 1'b0, 1'b1, 4'b0110, 4'd4};
    v1[5] = '{8'h63, 1'b0, 1'b1, 4'b0001, 4'd5};
    v1[6] = '{8'h61, 1'b0, 1'b0, 4'b0000, 4'd6};
    v1[7] = '{8'h62, 1'b1, 1'b1, 4'b0110, 4'd7};

    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Case 1: basic multi-pattern stream
    load_case1();
    start_frame();
    chk("busy_run", 64'(busy), 64'(1));
    for (int i = 0; i < 8; i++) send(v1[i].sym, v1[i].last, v1[i].ev, v1[i].em, v1[i].ep);
    finish_frame();

    // Case 2: back-pressure holds the first beat
    m_ready = 1'b0;
    start_frame();
    fork
      begin
        for (int i = 0; i < 8; i++) send(v1[i].sym, v1[i].last, v1[i].ev, v1[i].em, v1[i].ep);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 50) begin
          n++;
          @(negedge clk);
        end
        chk("stall_valid", 64'(m_valid), 64'(1));
        for (int c = 0; c < 5; c++) begin
          chk("stall_s_ready", 64'(s_ready), 64'(0));
          chk("stall_pos",     64'(m_pos),   64'(1));
          chk("stall_match",   64'(m_match), 64'(4'b0100));
          @(negedge clk);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    finish_frame();

    // Case 3: full-length pattern needs a full window
    load(0, "abcdefgh", 8);
    load(1, "", 0);
    load(2, "", 0);
    start_frame();
    t3 = "xabcdefgh";
    for (int i = 0; i < 9; i++)
      send(t3[i], (i == 8), (i == 8), 4'b0001, 4'(i));
    finish_frame();

    // Case 4: over-length write disables slot; writes during RUN are ignored
    load(0, "z", 9);
    start_frame();
    load(1, "z", 1);
    send(8'h7a, 1'b0, 1'b0, 4'b0000, 4'd0);
    send(8'h7a, 1'b1, 1'b1, 4'b0000, 4'd1);
    finish_frame();

    // Case 5: reset mid-frame clears outputs and table
    load_case1();
    start_frame();
    for (int i = 0; i < 3; i++) send(v1[i].sym, v1[i].last, v1[i].ev, v1[i].em, v1[i].ep);
    chk("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    start_frame();
    for (int i = 0; i < 8; i++) send(v1[i].sym, v1[i].last, v1[i].last, 4'b0000, v1[i].ep);
    finish_frame();

    // Case 6: length-1 pattern fires every symbol; position wraps
    load(0, "a", 1);
    start_frame();
    for (int i = 0; i < 20; i++) send(8'h61, (i == 19), 1'b1, 4'b0001, 4'(i % 16));
    finish_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
